// File: rtl/imem_loader.sv
// Instruction memory loader: fills byte-addressed instruction memory from a
// framed byte stream (N word count, 4N data bytes, XOR checksum) and serves fetch reads.
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | no session since reset; waiting for start
// S_HDR_HI | expecting word count N[15:8]
// S_HDR_LO | expecting word count N[7:0]; size check on acceptance
// S_DATA   | writing payload bytes to mem[wr_ptr]
// S_CHK    | expecting the XOR checksum of all payload bytes
// S_DONE   | last session completed OK (sticky until start/reset)
// S_ERR    | last session failed (oversize or bad checksum)

module imem_loader #(
   parameter int MEM_BYTES = 256,
   parameter int AW        = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   input  logic [31:0] rd_addr,
   output logic [31:0] rd_data,
   output logic        freeze,
   output logic        done,
   output logic        err,
   output logic [15:0] words_loaded
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR_HI,
      S_HDR_LO,
      S_DATA,
      S_CHK,
      S_DONE,
      S_ERR
   } state_t;

   state_t        state;
   state_t        state_nxt;

   logic [7:0]    mem [MEM_BYTES];
   logic [15:0]   n_words;
   logic [AW-1:0] wr_ptr;
   logic [1:0]    byte_cnt;
   logic [7:0]    checksum;

   logic          loading;
   logic          accept;
   logic          session_start;
   logic [15:0]   hdr_n;
   logic [17:0]   hdr_bytes;
   logic          oversize;
   logic          last_byte;

   assign loading = (state == S_HDR_HI) || (state == S_HDR_LO) ||
                    (state == S_DATA)   || (state == S_CHK);
   assign in_ready = loading;
   assign freeze   = loading;
   assign done     = (state == S_DONE);
   assign err      = (state == S_ERR);
   assign accept   = in_valid && loading;

   assign session_start = start &&
                          ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));

   // Size check is done at 18 bits so a huge N cannot wrap back into range.
   assign hdr_n     = {n_words[15:8], in_data};
   assign hdr_bytes = {hdr_n, 2'b00};
   assign oversize  = hdr_bytes > 18'(MEM_BYTES);

   assign last_byte = (byte_cnt == 2'd3) && ((words_loaded + 16'd1) == n_words);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_nxt = S_HDR_HI;
            end
         end
         S_HDR_HI: begin
            if (accept) begin
               state_nxt = S_HDR_LO;
            end
         end
         S_HDR_LO: begin
            if (accept) begin
               if (oversize) begin
                  state_nxt = S_ERR;
               end else if (hdr_n == 16'd0) begin
                  state_nxt = S_CHK;
               end else begin
                  state_nxt = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (accept && last_byte) begin
               state_nxt = S_CHK;
            end
         end
         S_CHK: begin
            if (accept) begin
               state_nxt = (in_data == checksum) ? S_DONE : S_ERR;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         n_words      <= 16'd0;
         wr_ptr       <= '0;
         byte_cnt     <= 2'd0;
         checksum     <= 8'd0;
         words_loaded <= 16'd0;
      end else if (session_start) begin
         wr_ptr       <= '0;
         byte_cnt     <= 2'd0;
         checksum     <= 8'd0;
         words_loaded <= 16'd0;
      end else if (accept) begin
         unique case (state)
            S_HDR_HI: n_words[15:8] <= in_data;
            S_HDR_LO: n_words[7:0]  <= in_data;
            S_DATA: begin
               wr_ptr   <= wr_ptr + AW'(1);
               checksum <= checksum ^ in_data;
               byte_cnt <= byte_cnt + 2'd1;
               if (byte_cnt == 2'd3) begin
                  words_loaded <= words_loaded + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Memory contents intentionally survive reset.
   always_ff @(posedge clk) begin
      if (accept && (state == S_DATA)) begin
         mem[wr_ptr] <= in_data;
      end
   end

   logic [AW-1:0] ra0;
   logic [AW-1:0] ra1;
   logic [AW-1:0] ra2;
   logic [AW-1:0] ra3;
   logic          unused_addr_hi;

   assign ra0 = rd_addr[AW-1:0];
   assign ra1 = ra0 + AW'(1);
   assign ra2 = ra0 + AW'(2);
   assign ra3 = ra0 + AW'(3);
   assign unused_addr_hi = ^rd_addr[31:AW];

   assign rd_data = {mem[ra0], mem[ra1], mem[ra2], mem[ra3]};

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed and randomized load sessions checked against
// a byte-array reference of instruction memory and the session outcome rules.

module tb_imem_loader;

   typedef logic [7:0] bq_t[$];

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_ready;
   logic [31:0] rd_addr = 32'd0;
   logic [31:0] rd_data;
   logic        freeze;
   logic        done;
   logic        err;
   logic [15:0] words_loaded;

   int checks = 0;
   int errors = 0;

   logic [7:0] ref_mem [256];
   bit         ref_known [256];

   imem_loader #(.MEM_BYTES(256), .AW(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .freeze       (freeze),
      .done         (done),
      .err          (err),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: a session is the header N, then 4N payload bytes landing at
   // addresses 0.., then one checksum byte equal to the XOR of the payload.
   task automatic model_session(input bq_t b, output bit e_done, output bit e_err,
                                output logic [15:0] e_words);
      int         n;
      logic [7:0] x;
      n       = {b[0], b[1]};
      e_done  = 1'b0;
      e_err   = 1'b0;
      e_words = 16'd0;
      x       = 8'h00;
      if (4 * n > 256) begin
         e_err = 1'b1;
         return;
      end
      for (int i = 0; i < 4 * n; i++) begin
         ref_mem[i]   = b[2 + i];
         ref_known[i] = 1'b1;
         x            = x ^ b[2 + i];
      end
      e_words = 16'(n);
      if (b[2 + 4 * n] == x) e_done = 1'b1;
      else                   e_err  = 1'b1;
   endtask

   task automatic make_stream(input int n, input bit bad, output bq_t s);
      logic [7:0] x;
      logic [7:0] b;
      x = 8'h00;
      s = {};
      s.push_back(8'(n >> 8));
      s.push_back(8'(n));
      for (int i = 0; i < 4 * n; i++) begin
         b = 8'($urandom);
         s.push_back(b);
         x = x ^ b;
      end
      s.push_back(bad ? (x ^ 8'(1 + $urandom_range(0, 254))) : x);
   endtask

   // mode 0: in_valid always high, 1: alternating 1-0-1, 2: random
   task automatic send(input bq_t s, input int mode, input string tag);
      int idx = 0;
      int cyc = 0;
      bit ph  = 1'b1;
      while (idx < s.size() && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         case (mode)
            0:       in_valid = 1'b1;
            1:       begin in_valid = ph; ph = !ph; end
            default: in_valid = 1'($urandom_range(0, 1));
         endcase
         in_data = in_valid ? s[idx] : 8'($urandom);
         if (in_valid && in_ready) idx++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'h00;
      check({tag, "_bytes_sent"}, 32'(idx), 32'(s.size()));
   endtask

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic check_mem(input string tag);
      logic [23:0] hi;
      for (int a = 0; a < 256; a++) begin
         if (ref_known[a] && ref_known[(a + 1) % 256] &&
             ref_known[(a + 2) % 256] && ref_known[(a + 3) % 256]) begin
            hi      = 24'($urandom);
            rd_addr = {hi, 8'(a)};
            #1;
            check({tag, "_rd"}, rd_data,
                  {ref_mem[a], ref_mem[(a + 1) % 256], ref_mem[(a + 2) % 256],
                   ref_mem[(a + 3) % 256]});
         end
      end
   endtask

   task automatic run_session(input bq_t s, input int mode, input string tag);
      bit          e_done;
      bit          e_err;
      logic [15:0] e_words;
      model_session(s, e_done, e_err, e_words);
      do_start();
      check({tag, "_freeze_on"}, 32'(freeze), 32'd1);
      check({tag, "_ready_on"}, 32'(in_ready), 32'd1);
      check({tag, "_done_clr"}, 32'(done), 32'd0);
      send(s, mode, tag);
      check({tag, "_done"}, 32'(done), 32'(e_done));
      check({tag, "_err"}, 32'(err), 32'(e_err));
      check({tag, "_words"}, 32'(words_loaded), 32'(e_words));
      check({tag, "_freeze_off"}, 32'(freeze), 32'd0);
      check({tag, "_ready_off"}, 32'(in_ready), 32'd0);
      check_mem(tag);
   endtask

   initial begin
      bq_t        s;
      bq_t        t1;
      logic [7:0] x;
      logic [7:0] b;

      for (int i = 0; i < 256; i++) begin
         ref_mem[i]   = 8'h00;
         ref_known[i] = 1'b0;
      end
      t1 = '{8'h00, 8'h02, 8'hE3, 8'hA0, 8'h00, 8'h14, 8'hE3, 8'hA0, 8'h1A, 8'h01, 8'h0F};

      repeat (3) @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_freeze", 32'(freeze), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_words", 32'(words_loaded), 32'd0);
      rst = 1'b1;

      // Good load
      run_session(t1, 0, "good");
      rd_addr = 32'd0; #1;
      check("good_rd0", rd_data, 32'hE3A00014);
      rd_addr = 32'd4; #1;
      check("good_rd4", rd_data, 32'hE3A01A01);

      // Overwrite with other data, then the same load under backpressure
      make_stream(2, 1'b0, s);
      run_session(s, 2, "scramble");
      run_session(t1, 1, "bp");
      rd_addr = 32'd0; #1;
      check("bp_rd0", rd_data, 32'hE3A00014);
      rd_addr = 32'd4; #1;
      check("bp_rd4", rd_data, 32'hE3A01A01);

      // Oversize header
      s = '{8'h00, 8'h41};
      run_session(s, 0, "oversize");

      // Checksum error
      s = t1;
      s[10] = 8'h0E;
      run_session(s, 0, "badsum");

      // Empty load
      s = '{8'h00, 8'h00, 8'h00};
      run_session(s, 0, "empty");

      // Randomized sessions
      for (int k = 0; k < 6; k++) begin
         make_stream($urandom_range(1, 16), 1'($urandom_range(0, 1)), s);
         run_session(s, $urandom_range(0, 2), "rand");
      end

      // Full-size load (N=64) with wrap pattern at the top of memory
      s = {};
      x = 8'h00;
      s.push_back(8'h00);
      s.push_back(8'h40);
      for (int i = 0; i < 256; i++) begin
         b = (i == 0) ? 8'h11 : (i == 1) ? 8'h22 : (i == 2) ? 8'h33 :
             (i == 255) ? 8'hAA : 8'($urandom);
         s.push_back(b);
         x = x ^ b;
      end
      s.push_back(x);
      run_session(s, 2, "full");
      rd_addr = 32'd255; #1;
      check("wrap_rd255", rd_data, 32'hAA112233);

      // Mid-session reset after 5 data bytes; start mid-session is ignored
      s = '{8'h00, 8'h04, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
      do_start();
      send(s, 0, "midrst");
      check("midrst_words1", 32'(words_loaded), 32'd1);
      do_start();
      check("midrst_start_ign_words", 32'(words_loaded), 32'd1);
      check("midrst_start_ign_frz", 32'(freeze), 32'd1);
      rst = 1'b0;
      #1;
      check("midrst_freeze", 32'(freeze), 32'd0);
      check("midrst_ready", 32'(in_ready), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_err", 32'(err), 32'd0);
      check("midrst_words", 32'(words_loaded), 32'd0);
      #2;
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         ref_mem[i] = s[2 + i];
      end
      check_mem("midrst_mem");

      // Next session restarts at address 0
      run_session(t1, 0, "after_rst");
      rd_addr = 32'd0; #1;
      check("after_rst_rd0", rd_data, 32'hE3A00014);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart to the instruction fetch stage: fills the byte-addressed instruction memory from a byte stream (boot or debug link) and serves the fetch stage's word reads.
- Holds the pipeline frozen while a load is in progress.
- Sits between the external load port and the IF stage.
- Memory order is big-endian: byte at address a is instruction bits [31:24].

Parameters:
- MEM_BYTES, 256, instruction memory size in bytes; power of two, at least 8.
- AW, 8, byte address width; log2(MEM_BYTES).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low
- start  in  1  pulse; begins a load session
- in_valid  in  1  byte available on in_data
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts a byte this cycle
- rd_addr  in  32  fetch byte address (adr_pc)
- rd_data  out  32  {mem[a], mem[a+1], mem[a+2], mem[a+3]}
- freeze  out  1  stall request to IF/pipeline
- done  out  1  last session completed OK
- err  out  1  last session failed
- words_loaded  out  16  words written in current/last session

Behaviour:
- States: IDLE, HDR_HI, HDR_LO, DATA, CHK, DONE, ERR.
- Reset (rst=0) forces:
  - state IDLE; wr_ptr, byte counter, word count, checksum and words_loaded = 0.
  - in_ready, freeze, done and err all 0.
  - Memory contents are not cleared.
- Transfer occurs only on a clk edge with in_valid & in_ready. in_ready = 1 exactly in HDR_HI, HDR_LO, DATA and CHK. in_data is ignored otherwise.
- freeze = 1 in HDR_HI, HDR_LO, DATA and CHK. It goes combinationally from state, with no extra latency.
- start handling:
  - In IDLE, DONE or ERR: start goes to HDR_HI. wr_ptr, checksum and words_loaded clear; done and err clear.
  - In any loading state: start is ignored.
- HDR_HI: the accepted byte becomes N[15:8]. Go to HDR_LO.
- HDR_LO: the accepted byte becomes N[7:0]. Then:
  - If 4*N > MEM_BYTES (computed at 18-bit width, no wrap): go to ERR.
  - Else if N == 0: go to CHK.
  - Else: go to DATA.
- DATA: each accepted byte is written to mem[wr_ptr] on that edge.
  - wr_ptr increments and checksum ^= byte.
  - After every 4th byte, words_loaded increments.
  - When words_loaded reaches N (on the edge that writes the byte at offset 4N-1): go to CHK.
- CHK: the accepted byte is compared to the running XOR of all data bytes.
  - Equal: go to DONE.
  - Not equal: go to ERR. Memory keeps the written bytes.
- DONE and ERR are sticky until the next start or reset. done = (state==DONE) and err = (state==ERR).
- Read path:
  - Combinational; rd_data reflects a same-cycle write only after the edge.
  - Byte addresses wrap modulo MEM_BYTES: use the low AW bits of rd_addr+k for k = 0..3.
  - Unaligned rd_addr is legal and returns the 4 consecutive bytes.
- A write is fully committed on the accepting edge; a load never produces partial-byte writes.
- Reset mid-session: return to IDLE and drop freeze. Bytes already written remain. A later session restarts at address 0.
- in_valid held low inside a state: the loader waits indefinitely with no timeout, and freeze stays high.

Test Plan:
1. Good load: start, then stream 00 02 E3 A0 00 14 E3 A0 1A 01 0F.
   - freeze=1 from the cycle after start until DONE; done=1, err=0, words_loaded=2.
   - rd_addr=0 returns E3A00014; rd_addr=4 returns E3A01A01.
2. Backpressure: repeat test 1 with in_valid toggling 1-0-1 every cycle.
   - Identical final memory and flags; no byte is duplicated or skipped.
3. Oversize: header 00 41 (N=65, 260 > 256).
   - err=1 and freeze=0 right after the HDR_LO edge; memory unchanged.
   - Header 00 40 (N=64) is accepted and reaches DATA.
4. Checksum error: test 1 with the final byte 0E.
   - err=1, done=0, words_loaded=2; memory holds the written bytes.
5. Empty load: header 00 00 then checksum 00.
   - done=1, words_loaded=0.
6. Mid-session reset and wrap:
   - Pull rst low after 5 data bytes: state IDLE, freeze=0, in_ready=0.
   - Preloaded mem[255]=AA, mem[0..2]=11 22 33: rd_addr=255 returns AA112233.
